// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive path.
package eth_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      FLUSH,
      DROP
   } rx_state_t;

   localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;
   localparam logic [1:0]  SFD_LAST_DIBIT       = 2'b11;
   localparam logic [1:0]  PREAMBLE_DIBIT       = 2'b01;

   function automatic logic [31:0] crc32_byte(
      input logic [31:0] crc,
      input logic [7:0]  data
   );
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Byte-wide reflected CRC-32 accumulator, no final inversion.
module eth_crc32_byte
   import eth_rx_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_init,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] r_crc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_crc <= CRC32_INIT;
      end else if (i_init) begin
         r_crc <= CRC32_INIT;
      end else if (i_byte_valid) begin
         r_crc <= crc32_byte(r_crc, i_data);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD detect, FCS strip and check,
// 8-bit AXI-Stream payload output with tlast/tuser.
module rmii_rx_deframer
   import eth_rx_pkg::*;
#(
   parameter int MIN_FRAME_BYTES = 64,
   parameter int MAX_FRAME_BYTES = 1522
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] rx_rmii_d,
   input  logic       rx_rmii_dv,
   output logic [7:0] rx_maxis_tdata,
   output logic       rx_maxis_tvalid,
   input  logic       rx_maxis_tready,
   output logic       rx_maxis_tlast,
   output logic       rx_maxis_tuser,
   output logic       stat_frame_ok,
   output logic       stat_crc_err,
   output logic       stat_overflow
);

   localparam logic [10:0] LP_MIN = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] LP_MAX = 11'(MAX_FRAME_BYTES);
   localparam logic [10:0] LP_SAT = 11'(MAX_FRAME_BYTES + 1);
   localparam logic [10:0] LP_HDR = 11'd5;

   rx_state_t       r_state;
   rx_state_t       w_state_nxt;
   logic [5:0]      r_shift;
   logic [1:0]      r_dibit_cnt;
   logic [10:0]     r_byte_cnt;
   logic [3:0][7:0] r_dly;
   logic [7:0]      r_pend;
   logic            r_seen01;
   logic            r_frame_err;
   logic            r_ovs;
   logic [7:0]      r_tdata;
   logic            r_tvalid;
   logic            r_tlast;
   logic            r_tuser;
   logic            r_stat_ok;
   logic            r_stat_crc;
   logic            r_stat_ovf;

   logic [31:0] w_crc;
   logic [7:0]  w_byte;
   logic        w_byte_done;
   logic        w_oversize;
   logic        w_push;
   logic        w_out_free;
   logic        w_pend_valid;
   logic        w_drop;
   logic        w_out_wr;
   logic        w_crc_init;
   logic        w_flush_emit;
   logic        w_crc_bad;
   logic        w_short;
   logic        w_tuser_fin;

   assign w_byte       = {rx_rmii_d, r_shift};
   assign w_byte_done  = (r_state == DATA) && rx_rmii_dv
                         && (r_dibit_cnt == 2'd3);
   assign w_oversize   = w_byte_done && (r_byte_cnt == LP_MAX);
   assign w_push       = w_byte_done && !w_oversize;
   assign w_out_free   = !r_tvalid || rx_maxis_tready;
   // Four bytes sit in the delay line, so a pending byte exists from byte 5.
   assign w_pend_valid = (r_byte_cnt >= LP_HDR);
   assign w_drop       = w_push && w_pend_valid && !w_out_free;
   assign w_out_wr     = (w_push && w_pend_valid && w_out_free)
                         || w_flush_emit;
   assign w_crc_bad    = (w_crc != CRC32_RESIDUE);
   assign w_short      = (r_byte_cnt < LP_MIN);
   assign w_tuser_fin  = r_ovs || w_crc_bad || r_frame_err || w_short;

   eth_crc32_byte u_crc (
      .clock        (clock),
      .reset        (reset),
      .i_init       (w_crc_init),
      .i_byte_valid (w_push),
      .i_data       (w_byte),
      .o_crc        (w_crc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_crc_init   = 1'b0;
      w_flush_emit = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (rx_rmii_dv) w_state_nxt = PREAMBLE;
         end
         PREAMBLE: begin
            if (!rx_rmii_dv) begin
               w_state_nxt = IDLE;
            end else if (rx_rmii_d == SFD_LAST_DIBIT) begin
               if (r_seen01) begin
                  w_state_nxt = DATA;
                  w_crc_init  = 1'b1;
               end else begin
                  w_state_nxt = DROP;
               end
            end else if (rx_rmii_d == 2'b10) begin
               w_state_nxt = DROP;
            end
         end
         DATA: begin
            if (!rx_rmii_dv || w_oversize) w_state_nxt = FLUSH;
         end
         FLUSH: begin
            if (!w_pend_valid) begin
               w_state_nxt = IDLE;
            end else if (w_out_free) begin
               w_flush_emit = 1'b1;
               w_state_nxt  = r_ovs ? DROP : IDLE;
            end
         end
         DROP: begin
            if (!rx_rmii_dv) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_shift     <= '0;
         r_dibit_cnt <= '0;
         r_byte_cnt  <= '0;
         r_dly       <= '0;
         r_pend      <= '0;
         r_seen01    <= 1'b0;
         r_frame_err <= 1'b0;
         r_ovs       <= 1'b0;
         r_stat_ok   <= 1'b0;
         r_stat_crc  <= 1'b0;
         r_stat_ovf  <= 1'b0;
      end else begin
         r_stat_ok  <= 1'b0;
         r_stat_crc <= 1'b0;
         r_stat_ovf <= w_drop;
         if (r_state == IDLE) begin
            r_seen01 <= rx_rmii_dv && (rx_rmii_d == PREAMBLE_DIBIT);
         end else if ((r_state == PREAMBLE) && rx_rmii_dv
                      && (rx_rmii_d == PREAMBLE_DIBIT)) begin
            r_seen01 <= 1'b1;
         end
         if (w_crc_init) begin
            r_dibit_cnt <= '0;
            r_byte_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_ovs       <= 1'b0;
         end
         if (r_state == DATA) begin
            if (rx_rmii_dv) begin
               r_shift     <= w_byte[7:2];
               r_dibit_cnt <= r_dibit_cnt + 2'd1;
            end else if (r_dibit_cnt != 2'd0) begin
               r_frame_err <= 1'b1;
            end
         end
         if (w_byte_done && (r_byte_cnt != LP_SAT)) begin
            r_byte_cnt <= r_byte_cnt + 11'd1;
         end
         if (w_oversize) r_ovs <= 1'b1;
         if (w_drop) r_frame_err <= 1'b1;
         if (w_push) begin
            r_dly  <= {r_dly[2:0], w_byte};
            r_pend <= r_dly[3];
         end
         // An oversize abort reports only as a flagged frame, not a CRC error.
         if (w_flush_emit) begin
            r_stat_ok  <= !w_tuser_fin;
            r_stat_crc <= w_crc_bad && !r_ovs;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
      end else if (w_out_wr) begin
         r_tdata  <= r_pend;
         r_tvalid <= 1'b1;
         r_tlast  <= w_flush_emit;
         r_tuser  <= w_flush_emit && w_tuser_fin;
      end else if (rx_maxis_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign rx_maxis_tdata  = r_tdata;
   assign rx_maxis_tvalid = r_tvalid;
   assign rx_maxis_tlast  = r_tlast;
   assign rx_maxis_tuser  = r_tuser;
   assign stat_frame_ok   = r_stat_ok;
   assign stat_crc_err    = r_stat_crc;
   assign stat_overflow   = r_stat_ovf;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Scoreboard bench for rmii_rx_deframer driven with RMII dibit frames.
module tb_rmii_rx_deframer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] rx_d = 2'b00;
   logic       rx_dv = 1'b0;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready = 1'b1;
   logic       tlast;
   logic       tuser;
   logic       s_ok;
   logic       s_crc;
   logic       s_ovf;

   int n_vec = 0;
   int n_err = 0;
   int n_beats = 0;
   int n_last = 0;
   int n_ok = 0;
   int n_crc = 0;
   int n_ovf = 0;
   int cyc = 0;
   int stall_from = 0;
   int stall_to = 0;
   bit sb_en = 1'b0;
   logic last_user = 1'b0;

   logic [9:0] exp_q[$];
   logic [7:0] frm[$];

   always #10 clk = ~clk;

   rmii_rx_deframer #(
      .MIN_FRAME_BYTES (64),
      .MAX_FRAME_BYTES (1522)
   ) dut (
      .clock           (clk),
      .reset           (rst),
      .rx_rmii_d       (rx_d),
      .rx_rmii_dv      (rx_dv),
      .rx_maxis_tdata  (tdata),
      .rx_maxis_tvalid (tvalid),
      .rx_maxis_tready (tready),
      .rx_maxis_tlast  (tlast),
      .rx_maxis_tuser  (tuser),
      .stat_frame_ok   (s_ok),
      .stat_crc_err    (s_crc),
      .stat_overflow   (s_ovf)
   );

   always @(posedge clk) begin
      #1;
      cyc++;
      tready = !(cyc >= stall_from && cyc < stall_to);
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst) begin
         if (s_ok) n_ok++;
         if (s_crc) n_crc++;
         if (s_ovf) n_ovf++;
         if (tvalid && tready) begin
            n_beats++;
            if (tlast) begin
               n_last++;
               last_user = tuser;
            end
            if (sb_en) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL sb_extra_beat got %h/%b/%b want none",
                           tdata, tlast, tuser);
               end else begin
                  e = exp_q.pop_front();
                  if ({tdata, tlast, tuser} !== e) begin
                     n_err++;
                     $display("FAIL sb_beat%0d got %h/%b/%b want %h/%b/%b",
                              n_beats, tdata, tlast, tuser,
                              e[9:2], e[1], e[0]);
                  end
               end
            end
         end
      end
   end

   function automatic logic [31:0] crc_next(
      input logic [31:0] c_in,
      input logic [7:0]  b
   );
      logic [31:0] c;
      c = c_in;
      for (int k = 0; k < 8; k++) begin
         if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
         else c = c >> 1;
      end
      return c;
   endfunction

   task automatic build_frame(input int n, input bit add_fcs);
      logic [31:0] crc;
      logic [31:0] fcs;
      frm.delete();
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         frm.push_back(i[7:0]);
         crc = crc_next(crc, i[7:0]);
      end
      if (add_fcs) begin
         fcs = ~crc;
         for (int j = 0; j < 4; j++) frm.push_back(fcs[8*j +: 8]);
      end
   endtask

   task automatic push_expected(input int n, input bit user);
      logic l;
      logic u;
      for (int i = 0; i < n; i++) begin
         l = (i == n - 1);
         u = l && user;
         exp_q.push_back({frm[i], l, u});
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rx_dv = 1'b1;
         rx_d = b[2*k +: 2];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_dv = 1'b0;
         rx_d = 2'b00;
      end
   endtask

   task automatic send_frame(input int abort_at);
      for (int p = 0; p < 8; p++) send_byte((p == 7) ? 8'hD5 : 8'h55);
      for (int i = 0; i < frm.size(); i++) begin
         if (i == abort_at) begin
            @(negedge clk);
            rx_dv = 1'b0;
            rst = 1'b1;
            repeat (3) @(negedge clk);
            n_vec++;
            if ({tdata, tvalid, tlast, tuser, s_ok, s_crc, s_ovf} !== 14'h0) begin
               n_err++;
               $display("FAIL abort_reset_outputs got %h want 0000",
                        {tdata, tvalid, tlast, tuser, s_ok, s_crc, s_ovf});
            end
            rst = 1'b0;
            idle(24);
            return;
         end
         send_byte(frm[i]);
      end
      idle(24);
   endtask

   task automatic wait_last(input int prev, input string nm);
      int t;
      t = 0;
      while (n_last == prev && t < 400) begin
         @(negedge clk);
         t++;
      end
      n_vec++;
      if (n_last == prev) begin
         n_err++;
         $display("FAIL %s_tlast_timeout got none want tlast", nm);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++;
      if ({tdata, tvalid, tlast, tuser, s_ok, s_crc, s_ovf} !== 14'h0) begin
         n_err++;
         $display("FAIL reset_outputs got %h want 0000",
                  {tdata, tvalid, tlast, tuser, s_ok, s_crc, s_ovf});
      end
      rst = 1'b0;
      idle(8);
   endtask

   task automatic test_good_frame(input string nm);
      int b0, k0, c0, l0;
      sb_en = 1'b1;
      build_frame(60, 1'b1);
      push_expected(60, 1'b0);
      b0 = n_beats; k0 = n_ok; c0 = n_crc; l0 = n_last;
      send_frame(-1);
      wait_last(l0, nm);
      idle(4);
      n_vec += 4;
      if (n_beats - b0 != 60) begin
         n_err++;
         $display("FAIL %s_beats got %0d want 60", nm, n_beats - b0);
      end
      if (n_ok - k0 != 1 || n_crc - c0 != 0) begin
         n_err++;
         $display("FAIL %s_stats got ok=%0d crc=%0d want ok=1 crc=0",
                  nm, n_ok - k0, n_crc - c0);
      end
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_sb_left got %0d want 0", nm, exp_q.size());
         exp_q.delete();
      end
      if (last_user !== 1'b0) begin
         n_err++;
         $display("FAIL %s_tuser got %b want 0", nm, last_user);
      end
   endtask

   task automatic test_crc_error();
      int k0, c0, l0;
      sb_en = 1'b1;
      build_frame(60, 1'b1);
      frm[10] = frm[10] ^ 8'h01;
      push_expected(60, 1'b1);
      k0 = n_ok; c0 = n_crc; l0 = n_last;
      send_frame(-1);
      wait_last(l0, "crc");
      idle(4);
      n_vec += 2;
      if (n_ok - k0 != 0 || n_crc - c0 != 1) begin
         n_err++;
         $display("FAIL crc_stats got ok=%0d crc=%0d want ok=0 crc=1",
                  n_ok - k0, n_crc - c0);
      end
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL crc_sb_left got %0d want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_overflow();
      int b0, v0, l0;
      sb_en = 1'b0;
      build_frame(60, 1'b1);
      b0 = n_beats; v0 = n_ovf; l0 = n_last;
      stall_from = cyc + 32 + 4 * 30;
      stall_to = stall_from + 12;
      send_frame(-1);
      wait_last(l0, "ovf");
      idle(4);
      stall_from = 0;
      stall_to = 0;
      n_vec += 3;
      if (n_ovf - v0 < 1) begin
         n_err++;
         $display("FAIL ovf_pulse got %0d want >=1", n_ovf - v0);
      end
      if (n_beats - b0 >= 60 || n_beats - b0 == 0) begin
         n_err++;
         $display("FAIL ovf_beats got %0d want 1..59", n_beats - b0);
      end
      if (last_user !== 1'b1 || n_last - l0 != 1) begin
         n_err++;
         $display("FAIL ovf_tlast got user=%b n=%0d want user=1 n=1",
                  last_user, n_last - l0);
      end
   endtask

   task automatic test_runt();
      int b0, k0, c0, v0;
      sb_en = 1'b1;
      build_frame(3, 1'b0);
      b0 = n_beats; k0 = n_ok; c0 = n_crc; v0 = n_ovf;
      send_frame(-1);
      idle(16);
      n_vec += 2;
      if (n_beats - b0 != 0) begin
         n_err++;
         $display("FAIL runt_beats got %0d want 0", n_beats - b0);
      end
      if (n_ok - k0 != 0 || n_crc - c0 != 0 || n_ovf - v0 != 0) begin
         n_err++;
         $display("FAIL runt_stats got %0d/%0d/%0d want 0/0/0",
                  n_ok - k0, n_crc - c0, n_ovf - v0);
      end
      test_good_frame("after_runt");
   endtask

   task automatic test_oversize();
      int b0, l0, k0;
      sb_en = 1'b1;
      build_frame(1600, 1'b0);
      push_expected(1518, 1'b1);
      b0 = n_beats; l0 = n_last; k0 = n_ok;
      send_frame(-1);
      wait_last(l0, "big");
      idle(8);
      n_vec += 3;
      if (n_beats - b0 != 1518 || n_last - l0 != 1) begin
         n_err++;
         $display("FAIL big_beats got %0d/%0d want 1518/1",
                  n_beats - b0, n_last - l0);
      end
      if (n_ok - k0 != 0) begin
         n_err++;
         $display("FAIL big_ok got %0d want 0", n_ok - k0);
      end
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL big_sb_left got %0d want 0", exp_q.size());
         exp_q.delete();
      end
      test_good_frame("after_big");
   endtask

   task automatic test_reset_abort();
      int l0;
      sb_en = 1'b0;
      build_frame(60, 1'b1);
      l0 = n_last;
      send_frame(20);
      idle(16);
      n_vec++;
      if (n_last - l0 != 0) begin
         n_err++;
         $display("FAIL abort_tlast got %0d want 0", n_last - l0);
      end
      test_good_frame("after_abort");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_good_frame("good");
      test_crc_error();
      test_overflow();
      test_runt();
      test_oversize();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
